// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM/WB stage: FSM state encoding,
// default widths and the word-alignment check.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );

endinterface

// File: rtl/mem_access_timer.sv
// Saturating cycle counter for an outstanding memory access; flags the
// last permitted wait cycle so the FSM can abort on the following edge.
module mem_access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // TIMEOUT of zero means wait forever
  assign expired = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: performs the data-memory access for the EX/MEM slot and
// registers the MEM/WB fields, stalling upstream while a request is open.
//
//   state  | meaning
//   IDLE   | no access open; accept next EX/MEM slot
//   ACCESS | request on the bus, waiting for dmem_ready or timeout
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [31:0]       instruction_in,
  input  logic [DATA_W-1:0] ALU_Results_in,
  input  logic [DATA_W-1:0] Write_Data_in,
  input  logic [4:0]        Rd_in,
  input  logic              MemToReg_in,
  input  logic              Mem_Read_in,
  input  logic              Mem_Write_in,
  input  logic              RegWrite_in,
  mem_wb_stage_if.master    dmem,
  output logic              stall_out,
  output logic              wb_valid,
  output logic [31:0]       instruction_out,
  output logic [DATA_W-1:0] Read_Data_out,
  output logic [DATA_W-1:0] ALU_Results_out,
  output logic [4:0]        Rd_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic              err_out
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              err_q, err_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic              m2r_q, m2r_d;
  logic              regwr_q, regwr_d;
  logic              capture;
  logic              timer_clr, timer_en, timer_expired;

  mem_access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    regwr_d    = regwr_q;
    capture    = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!(Mem_Read_in || Mem_Write_in)) begin
            capture    = 1'b1;
            rdata_d    = '0;
            regwr_d    = RegWrite_in;
            wb_valid_d = 1'b1;
          end else if (is_misaligned(ALU_Results_in[1:0])) begin
            capture    = 1'b1;
            rdata_d    = '0;
            regwr_d    = 1'b0;
            err_d      = 1'b1;
            wb_valid_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            we_d      = Mem_Write_in;
            addr_d    = ALU_Results_in[ADDR_W-1:0];
            wdata_d   = Write_Data_in;
            timer_clr = 1'b1;
          end
        end
      end
      ACCESS: begin
        // ready takes priority over an abort landing on the same edge
        if (dmem.dmem_ready) begin
          state_d    = IDLE;
          capture    = 1'b1;
          rdata_d    = (Mem_Read_in && !Mem_Write_in) ? dmem.dmem_rdata : '0;
          regwr_d    = RegWrite_in;
          wb_valid_d = 1'b1;
        end else if (timer_expired) begin
          state_d    = IDLE;
          capture    = 1'b1;
          rdata_d    = '0;
          regwr_d    = 1'b0;
          err_d      = 1'b1;
          wb_valid_d = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    instr_d = capture ? instruction_in : instr_q;
    alu_d   = capture ? ALU_Results_in : alu_q;
    rd_d    = capture ? Rd_in          : rd_q;
    m2r_d   = capture ? MemToReg_in    : m2r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      m2r_q      <= 1'b0;
      regwr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      m2r_q      <= m2r_d;
      regwr_q    <= regwr_d;
    end
  end

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign stall_out       = (state_q == ACCESS);
  assign wb_valid        = wb_valid_q;
  assign err_out         = err_q;
  assign instruction_out = instr_q;
  assign Read_Data_out   = rdata_q;
  assign ALU_Results_out = alu_q;
  assign Rd_out          = rd_q;
  assign MemToReg_out    = m2r_q;
  assign RegWrite_out    = regwr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus random instruction stream,
// checked against a transaction-level model of the expected writeback.
module tb_mem_wb_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [31:0]   instruction_in;
  logic [DW-1:0] ALU_Results_in, Write_Data_in;
  logic [4:0]    Rd_in;
  logic          MemToReg_in, Mem_Read_in, Mem_Write_in, RegWrite_in;
  logic          stall_out, wb_valid, err_out;
  logic [31:0]   instruction_out;
  logic [DW-1:0] Read_Data_out, ALU_Results_out;
  logic [4:0]    Rd_out;
  logic          MemToReg_out, RegWrite_out;

  mem_wb_stage_if #(.DATA_W(DW), .ADDR_W(AW)) dmem ();

  mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .instruction_in  (instruction_in),
    .ALU_Results_in  (ALU_Results_in),
    .Write_Data_in   (Write_Data_in),
    .Rd_in           (Rd_in),
    .MemToReg_in     (MemToReg_in),
    .Mem_Read_in     (Mem_Read_in),
    .Mem_Write_in    (Mem_Write_in),
    .RegWrite_in     (RegWrite_in),
    .dmem            (dmem),
    .stall_out       (stall_out),
    .wb_valid        (wb_valid),
    .instruction_out (instruction_out),
    .Read_Data_out   (Read_Data_out),
    .ALU_Results_out (ALU_Results_out),
    .Rd_out          (Rd_out),
    .MemToReg_out    (MemToReg_out),
    .RegWrite_out    (RegWrite_out),
    .err_out         (err_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // expected MEM/WB register contents
  logic [31:0]   e_instr;
  logic [DW-1:0] e_alu, e_rdata;
  logic [4:0]    e_rd;
  logic          e_m2r, e_rw;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, ".instr"}, instruction_out, e_instr);
    chk({tag, ".alu"},   ALU_Results_out, e_alu);
    chk({tag, ".rdata"}, Read_Data_out,   e_rdata);
    chk({tag, ".rd"},    Rd_out,          e_rd);
    chk({tag, ".m2r"},   MemToReg_out,    e_m2r);
    chk({tag, ".rw"},    RegWrite_out,    e_rw);
  endtask

  task automatic chk_wb(input string tag, input logic exp_err);
    chk({tag, ".wb_valid"}, wb_valid,      1'b1);
    chk({tag, ".err"},      err_out,       exp_err);
    chk({tag, ".req"},      dmem.dmem_req, 1'b0);
    chk({tag, ".stall"},    stall_out,     1'b0);
    chk_fields(tag);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".wb_valid"}, wb_valid,      1'b0);
    chk({tag, ".err"},      err_out,       1'b0);
    chk({tag, ".req"},      dmem.dmem_req, 1'b0);
    chk({tag, ".stall"},    stall_out,     1'b0);
    chk_fields(tag);
  endtask

  task automatic zero_model();
    e_instr = '0; e_alu = '0; e_rdata = '0; e_rd = '0; e_m2r = 1'b0; e_rw = 1'b0;
  endtask

  // lat = ACCESS cycle on which dmem_ready is raised (beyond TO never arrives)
  task automatic do_instr(input string tag, input logic [31:0] instr, input logic [DW-1:0] alu,
                          input logic [DW-1:0] wd, input logic [4:0] rd, input logic m2r,
                          input logic mr, input logic mw, input logic rw, input int lat,
                          input logic [DW-1:0] mem_data);
    logic mis, tmo;
    int   n_end;
    valid_in = 1'b1; instruction_in = instr; ALU_Results_in = alu; Write_Data_in = wd;
    Rd_in = rd; MemToReg_in = m2r; Mem_Read_in = mr; Mem_Write_in = mw; RegWrite_in = rw;
    mis = (alu[1:0] != 2'b00);
    if (!(mr || mw) || mis) begin
      tick();
      valid_in = 1'b0;
      e_instr = instr; e_alu = alu; e_rd = rd; e_m2r = m2r;
      e_rw = (mr || mw) ? 1'b0 : rw;
      e_rdata = '0;
      chk_wb(tag, (mr || mw));
    end else begin
      tmo   = (lat > TO);
      n_end = tmo ? TO : lat;
      tick();
      for (int c = 1; c <= n_end; c++) begin
        chk({tag, ".acc_req"},   dmem.dmem_req,   1'b1);
        chk({tag, ".acc_stall"}, stall_out,       1'b1);
        chk({tag, ".acc_addr"},  dmem.dmem_addr,  alu[AW-1:0]);
        chk({tag, ".acc_we"},    dmem.dmem_we,    mw);
        chk({tag, ".acc_wdata"}, dmem.dmem_wdata, wd);
        chk({tag, ".acc_wbv"},   wb_valid,        1'b0);
        dmem.dmem_ready = (c == lat);
        dmem.dmem_rdata = (c == lat) ? mem_data : DW'($urandom());
        tick();
      end
      dmem.dmem_ready = 1'b0;
      valid_in = 1'b0;
      e_instr = instr; e_alu = alu; e_rd = rd; e_m2r = m2r;
      e_rw    = tmo ? 1'b0 : rw;
      e_rdata = (!tmo && mr && !mw) ? mem_data : '0;
      chk_wb(tag, tmo);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [DW-1:0] a;
    int kind;
    valid_in = 0; instruction_in = 0; ALU_Results_in = 0; Write_Data_in = 0; Rd_in = 0;
    MemToReg_in = 0; Mem_Read_in = 0; Mem_Write_in = 0; RegWrite_in = 0;
    dmem.dmem_ready = 0; dmem.dmem_rdata = 0;
    rst = 1'b1;
    tick(); tick();
    zero_model();
    chk("rst.we",    dmem.dmem_we,    1'b0);
    chk("rst.addr",  dmem.dmem_addr,  '0);
    chk("rst.wdata", dmem.dmem_wdata, '0);
    chk_quiet("rst");
    rst = 1'b0;
    tick(); chk_quiet("bubble0");
    tick(); chk_quiet("bubble1");

    do_instr("alu", 32'h0000_0033, 32'h0000_002A, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    tick(); chk_quiet("hold");
    do_instr("load3", 32'h0000_0003, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'hDEAD_BEEF);
    do_instr("store1", 32'h0000_0023, 32'h0000_0040, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    do_instr("misalign", 32'h0000_0003, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0);
    do_instr("timeout", 32'h0000_0003, 32'h0000_0200, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 99, 32'h5555);
    do_instr("rdy_at_abort", 32'h0000_0003, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, TO, 32'hCAFE_F00D);
    do_instr("rw_both", 32'h0000_0023, 32'h0000_0400, 32'h77, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 2, 32'h1111_2222);
    do_instr("b2b0", 32'h1, 32'h11, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    do_instr("b2b1", 32'h2, 32'h22, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    do_instr("b2b2", 32'h3, 32'h33, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // reset landing in the second ACCESS cycle abandons the request
    valid_in = 1'b1; instruction_in = 32'h3; ALU_Results_in = 32'h500; Mem_Read_in = 1'b1;
    Mem_Write_in = 1'b0; RegWrite_in = 1'b1; Rd_in = 5'd8; MemToReg_in = 1'b1;
    tick();
    chk("mrst.req1", dmem.dmem_req, 1'b1);
    tick();
    chk("mrst.req2", dmem.dmem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; valid_in = 1'b0; Mem_Read_in = 1'b0;
    zero_model();
    chk_quiet("mrst");
    tick(); chk_quiet("mrst_after");

    for (int i = 0; i < 80; i++) begin
      r = $urandom();
      a = DW'($urandom());
      kind = $urandom_range(0, 4);
      if (kind != 4) a[1:0] = 2'b00;
      case (kind)
        0: do_instr("rnd_alu", r, a, DW'($urandom()), 5'($urandom()), 1'b0, 1'b0, 1'b0, 1'($urandom()), 0, 0);
        1: do_instr("rnd_ld", r, a, DW'($urandom()), 5'($urandom()), 1'b1, 1'b1, 1'b0, 1'b1,
                    $urandom_range(1, TO + 2), DW'($urandom()));
        2: do_instr("rnd_st", r, a, DW'($urandom()), 5'($urandom()), 1'b0, 1'b0, 1'b1, 1'b0,
                    $urandom_range(1, TO + 2), DW'($urandom()));
        default: do_instr("rnd_mis", r, a, DW'($urandom()), 5'($urandom()), 1'($urandom()),
                          1'b1, 1'($urandom()), 1'b1, 1, 0);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        tick(); chk_quiet("rnd_bubble");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline latch. Takes the registered EX/MEM fields and performs the data-memory access over a variable-latency req/ready bus.
- Produces the registered MEM/WB fields for writeback.
- Asserts stall upstream while an access is outstanding. Aborts accesses on misalignment or timeout.

Parameters:
- DATA_W, 32, data/ALU word width
- ADDR_W, 32, data-memory address width (low ADDR_W bits of ALU result)
- TIMEOUT, 16, max cycles in ACCESS awaiting dmem_ready; 0 disables timeout

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- instruction_in  in  32  instruction word, passed through
- ALU_Results_in  in  DATA_W  address for loads/stores; result otherwise
- Write_Data_in  in  DATA_W  store data
- Rd_in  in  5  destination register
- MemToReg_in, Mem_Read_in, Mem_Write_in, RegWrite_in  in  1 each  control
- dmem_req  out  1  access request, held until ready
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word address (byte address, bits[1:0]=0)
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready
- dmem_ready  in  1  completes the current request
- stall_out  out  1  upstream must hold EX/MEM contents
- wb_valid  out  1  one-cycle pulse: MEM/WB fields updated
- instruction_out  out  32  registered passthrough
- Read_Data_out  out  DATA_W  load data (0 for non-loads)
- ALU_Results_out  out  DATA_W  registered ALU result
- Rd_out  out  5  registered destination register
- MemToReg_out, RegWrite_out  out  1 each  registered control
- err_out  out  1  pulses with wb_valid on misalign or timeout

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, timer=0; all outputs 0, including dmem_req, stall_out, wb_valid and err_out. Applies mid-access: the request is dropped immediately and the memory side tolerates an abandoned request.
- FSM states: IDLE, ACCESS.
- IDLE, valid_in=0: stay IDLE. wb_valid=0. MEM/WB fields hold their previous values.
- IDLE, valid_in=1, no memory op: at the edge, latch fields; Read_Data_out=0; wb_valid=1 next cycle. Latency 1.
- IDLE, valid_in=1, Mem_Read or Mem_Write, ALU_Results_in[1:0]!=0 (misaligned):
  - No bus request is issued.
  - Latch fields with RegWrite_out=0; err_out=1, wb_valid=1 next cycle.
- IDLE, valid_in=1, aligned memory op: at the edge, register dmem_addr, dmem_wdata and dmem_we; go to ACCESS, timer=0.
  - dmem_we = Mem_Write_in. Both Read and Write set: write wins and Read_Data_out=0.
  - dmem_req=1 and stall_out=1 from the next cycle onward.
- ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata remain stable until the completing edge. stall_out=1 throughout.
- ACCESS, dmem_ready=1: at that edge, latch fields; Read_Data_out = dmem_rdata for loads, else 0. Then go to IDLE; next cycle wb_valid=1, dmem_req=0, stall_out=0.
  - Minimum memory-op latency: request cycle + 1 = wb_valid two cycles after acceptance.
- ACCESS, dmem_ready=0: timer increments, saturating.
- Timeout: if TIMEOUT!=0 and the timer reaches TIMEOUT-1 without ready, the next edge aborts.
  - IDLE, dmem_req=0, err_out=1, wb_valid=1, RegWrite_out=0, Read_Data_out=0.
  - If dmem_ready arrives on that same abort edge, ready wins and the access completes normally.
- stall_out is a registered function of state only (state==ACCESS). Inputs arriving while in ACCESS are ignored; upstream holds them.
- wb_valid and err_out are single-cycle pulses. Back-to-back non-memory instructions give wb_valid=1 every cycle.
- Rd_out=0 passes through unchanged; x0 suppression belongs to the register file.
- ALU_Results_out always carries the instruction's ALU result, including on error.

Decomposition:
- Shared package pipe_pkg: state enum {IDLE, ACCESS}; DATA_W/ADDR_W defaults; misalignment mask constant (2'b11).
- One natural sub-module: mem_access_timer, a saturating counter with clear, enable and TIMEOUT compare output. The rest is a single FSM plus output registers.

Test Plan:
- Reset then bubbles: rst 2 cycles, valid_in=0 -> all outputs 0, no dmem_req.
- ALU op: valid_in=1, RegWrite_in=1, ALU_Results_in=0x0000_002A, Rd_in=5 -> next cycle wb_valid=1, ALU_Results_out=0x2A, Rd_out=5, stall_out=0.
- Load with 3-cycle memory: Mem_Read_in=1, addr 0x100, dmem_ready after 3 ACCESS cycles, dmem_rdata=0xDEAD_BEEF.
  - dmem_req=1, dmem_addr=0x100 for 3 cycles; stall_out=1.
  - Then wb_valid=1, Read_Data_out=0xDEADBEEF, MemToReg_out=1.
- Store with ready on first ACCESS cycle: Mem_Write_in=1, addr 0x40, Write_Data_in=0x1234.
  - dmem_we=1, dmem_wdata=0x1234 for 1 cycle; wb_valid two cycles after acceptance.
- Misaligned load, addr 0x102 -> no dmem_req; next cycle wb_valid=1, err_out=1, RegWrite_out=0.
- Timeout and mid-access reset, TIMEOUT=4, dmem_ready held 0:
  - Abort after 4 ACCESS cycles with err_out=1, RegWrite_out=0, dmem_req=0.
  - Repeat with rst asserted in the 2nd ACCESS cycle -> dmem_req=0, stall_out=0 the next cycle, no wb_valid.
